// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide
// over DATA_WIDTH cycles, holding the pipeline via stall until a one-cycle result beat.
module ex_muldiv_ctrl #(
   parameter int  DATA_WIDTH    = 32,
   parameter int  NUM_REGISTERS = 32,
   localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               funct3,
   input  logic [DATA_WIDTH-1:0]    opr_a,
   input  logic [DATA_WIDTH-1:0]    opr_b,
   input  logic [ADDRESS_WIDTH-1:0] rd_in,
   input  logic                     flush,
   output logic                     stall,
   output logic                     res_valid,
   output logic [DATA_WIDTH-1:0]    res,
   output logic [ADDRESS_WIDTH-1:0] rd_out
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t                   state_q;
   logic [CW-1:0]            count_q;
   logic [2:0]               funct3_q;
   logic [DATA_WIDTH-1:0]    hi_q, lo_q, opB_q, res_q;
   logic                     negRes_q;
   logic [ADDRESS_WIDTH-1:0] rdLat_q, rdOut_q;

   logic                     aNeg, bNeg, divZero, overflow, fastPath, negFlag;
   logic [DATA_WIDTH-1:0]    aMag, bMag, fastRes;
   logic [DATA_WIDTH:0]      mulSum, divShift;
   logic [DATA_WIDTH-1:0]    divDiff, hi_d, lo_d, finalRes;
   logic                     divGe;
   logic [2*DATA_WIDTH-1:0]  prod, prodFix;
   logic [DATA_WIDTH-1:0]    quotFix, remFix;

   // Request decode: signed operands become magnitudes, corner cases bypass the iteration.
   always_comb begin
      aNeg     = (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110)
                 && opr_a[DATA_WIDTH-1];
      bNeg     = (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110) && opr_b[DATA_WIDTH-1];
      aMag     = aNeg ? -opr_a : opr_a;
      bMag     = bNeg ? -opr_b : opr_b;
      divZero  = (opr_b == '0);
      overflow = (funct3 == 3'b100 || funct3 == 3'b110) && (opr_a == MIN_NEG) && (opr_b == '1);
      fastPath = funct3[2] && (divZero || overflow);
      if (divZero) fastRes = funct3[1] ? opr_a : '1;
      else         fastRes = funct3[1] ? '0 : MIN_NEG;
      negFlag  = (funct3[2] && funct3[1]) ? aNeg : (aNeg ^ bNeg);
   end

   // One unsigned step: hi holds partial product / remainder, lo the multiplier / quotient.
   always_comb begin
      mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : '0);
      divShift = {hi_q, lo_q[DATA_WIDTH-1]};
      divGe    = (divShift >= {1'b0, opB_q});
      divDiff  = divShift[DATA_WIDTH-1:0] - opB_q;
      if (funct3_q[2]) begin
         hi_d = divGe ? divDiff : divShift[DATA_WIDTH-1:0];
         lo_d = {lo_q[DATA_WIDTH-2:0], divGe};
      end else begin
         {hi_d, lo_d} = {mulSum, lo_q[DATA_WIDTH-1:1]};
      end
      prod    = {hi_d, lo_d};
      prodFix = negRes_q ? -prod : prod;
      quotFix = negRes_q ? -lo_d : lo_d;
      remFix  = negRes_q ? -hi_d : hi_d;
      case (funct3_q)
         3'b000:          finalRes = prodFix[DATA_WIDTH-1:0];
         3'b100, 3'b101:  finalRes = quotFix;
         3'b110, 3'b111:  finalRes = remFix;
         default:         finalRes = prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
      endcase
   end

   // Sequencer; flush outranks everything but reset and never produces a result beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         funct3_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opB_q    <= '0;
         negRes_q <= 1'b0;
         rdLat_q  <= '0;
         rdOut_q  <= '0;
         res_q    <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  funct3_q <= funct3;
                  rdLat_q  <= rd_in;
                  negRes_q <= negFlag;
                  opB_q    <= bMag;
                  hi_q     <= '0;
                  lo_q     <= aMag;
                  count_q  <= '0;
                  if (fastPath) begin
                     res_q   <= fastRes;
                     rdOut_q <= rd_in;
                     state_q <= DONE;
                  end else begin
                     state_q <= ITER;
                  end
               end
            end
            ITER: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
               if (count_q == LAST) begin
                  count_q <= '0;
                  res_q   <= finalRes;
                  rdOut_q <= rdLat_q;
                  state_q <= DONE;
               end else begin
                  count_q <= count_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign res       = res_q;
   assign rd_out    = rdOut_q;
   assign stall     = ((state_q == IDLE) && req_valid && !fastPath && !flush) || (state_q == ITER);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: directed M-extension ops push expected results,
// an independent monitor pops and compares on every result beat.
module tb_ex_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  funct3 = '0;
   logic [31:0] opr_a = '0;
   logic [31:0] opr_b = '0;
   logic [4:0]  rd_in = '0;
   logic        flush = 1'b0;
   logic        stall;
   logic        res_valid;
   logic [31:0] res;
   logic [4:0]  rd_out;

   typedef struct {
      logic [31:0] expRes;
      logic [31:0] expRd;
      logic [31:0] expCycle;
   } expect_t;

   expect_t expQueue[$];
   int vectors = 0;
   int miscompares = 0;
   int cycleCnt = 0;

   ex_muldiv_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .funct3(funct3), .opr_a(opr_a), .opr_b(opr_b), .rd_in(rd_in), .flush(flush),
      .stall(stall), .res_valid(res_valid), .res(res), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   // Edge counter used to time result beats relative to the acceptance edge.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every result beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (expQueue.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedBeat: res 0x%08h rd %0d with nothing outstanding", res, rd_out);
         end else begin
            expect_t e;
            e = expQueue.pop_front();
            checkOutput("res", res, e.expRes);
            checkOutput("rdOut", 32'(rd_out), e.expRd);
            checkOutput("latency", 32'(cycleCnt), e.expCycle);
         end
      end
   end

   // Issue one op, push its expectation, then wait for the beat while counting stall cycles.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] expRes, input bit fast);
      expect_t e;
      int  stallCnt;
      bit  done;
      @(negedge clk);
      funct3 = f3; opr_a = a; opr_b = b; rd_in = rd; req_valid = 1'b1;
      #1;
      checkOutput("stallAtRequest", 32'(stall), fast ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.expRes   = expRes;
      e.expRd    = 32'(rd);
      e.expCycle = 32'(cycleCnt + (fast ? 0 : 32));
      expQueue.push_back(e);
      stallCnt = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (res_valid) begin
            done = 1'b1;
            checkOutput("stallInDone", 32'(stall), 32'd0);
            checkOutput("readyInDone", 32'(req_ready), 32'd0);
         end else if (stall) begin
            stallCnt++;
         end
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("[TB] FAIL timeout: no result beat for funct3=%0d within 40 cycles", f3);
      end
      checkOutput("stallCycles", 32'(stallCnt), fast ? 32'd0 : 32'd32);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("resetReady", 32'(req_ready), 32'd1);
      checkOutput("resetValid", 32'(res_valid), 32'd0);
      checkOutput("resetRes", res, 32'd0);
      checkOutput("resetRd", 32'(rd_out), 32'd0);
      checkOutput("resetStall", 32'(stall), 32'd0);

      // Iterative multiplies and divides
      applyStimulus(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
      applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0);
      applyStimulus(3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 1'b0);
      applyStimulus(3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0);
      applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 1'b0);
      applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 1'b0);
      applyStimulus(3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       1'b0);
      applyStimulus(3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        1'b0);
      // Fast path: divide by zero and signed overflow
      applyStimulus(3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1'b1);
      applyStimulus(3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1'b1);
      applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1);
      applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b1);

      // flush together with a request in IDLE: nothing accepted, no stall
      @(negedge clk);
      funct3 = 3'b101; opr_a = 32'd100; opr_b = 32'd7; rd_in = 5'd20;
      req_valid = 1'b1; flush = 1'b1;
      #1;
      checkOutput("stallFlushIdle", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0; flush = 1'b0;
      checkOutput("readyAfterFlushIdle", 32'(req_ready), 32'd1);
      checkOutput("stallAfterFlushIdle", 32'(stall), 32'd0);

      // flush at ITER cycle 10, then a request two cycles later
      @(negedge clk);
      funct3 = 3'b101; opr_a = 32'd100; opr_b = 32'd7; rd_in = 5'd21; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("stallIterBeforeFlush", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("readyAfterFlush", 32'(req_ready), 32'd1);
      checkOutput("validAfterFlush", 32'(res_valid), 32'd0);
      checkOutput("stallAfterFlush", 32'(stall), 32'd0);
      @(posedge clk);
      applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFE, 1'b0);

      // Reset asserted at ITER cycle 20 aborts without a beat and clears outputs
      @(negedge clk);
      funct3 = 3'b000; opr_a = 32'd7; opr_b = 32'hFFFFFFFD; rd_in = 5'd22; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstMidReady", 32'(req_ready), 32'd1);
      checkOutput("rstMidValid", 32'(res_valid), 32'd0);
      checkOutput("rstMidRes", res, 32'd0);
      checkOutput("rstMidRd", 32'(rd_out), 32'd0);
      checkOutput("rstMidStall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(3'b111, 32'd100, 32'd7, 5'd3, 32'd2, 1'b0);

      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("queueDrained", 32'(expQueue.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Sequencer for an iterative RV32M multiply/divide unit that sits beside the execute-stage ALU. It accepts one M-extension operation from EX and runs a radix-2 shift-add multiply or restoring divide over DATA_WIDTH cycles. While the operation runs it holds the pipeline through a stall output. It returns the result and destination register to EX in a single-cycle DONE beat.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
NUM_REGISTERS, 32, register file size.
ADDRESS_WIDTH, $clog2(NUM_REGISTERS), localparam, rd width.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  EX presents an M-extension op (opcode OP, funct7=0000001)
req_ready  output  1  controller can accept; high only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opr_a  input  DATA_WIDTH  rs1 value
opr_b  input  DATA_WIDTH  rs2 value
rd_in  input  ADDRESS_WIDTH  destination register
flush  input  1  kill in-flight op (branch/trap)
stall  output  1  freeze IF/ID/EX while an op is pending
res_valid  output  1  result beat
res  output  DATA_WIDTH  result
rd_out  output  ADDRESS_WIDTH  destination of result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge.
- Reset forces state IDLE, counter 0, res_valid 0, res 0, rd_out 0, and all internal operand/accumulator registers to 0. Reset mid-operation aborts with no result beat.
- States: IDLE, ITER, DONE.
- IDLE: req_ready=1. Acceptance occurs on an edge with req_valid & req_ready & !flush; at acceptance the controller latches funct3, operands and rd.
  - Fast path, checked at acceptance, goes straight to DONE with no ITER cycles:
    - divide by zero (opr_b=0): DIV/DIVU return all ones; REM/REMU return opr_a.
    - signed overflow (DIV/REM with opr_a=0x80000000 and opr_b=all ones): DIV returns 0x80000000; REM returns 0.
  - Otherwise the next state is ITER with counter 0.
- Operand preparation for the iterative path:
  - Signed operands (MULH, MULHSU's rs1, DIV, REM) are converted to magnitude at acceptance.
  - A result-negate flag is recorded.
  - The core runs unsigned and produces a 2*DATA_WIDTH product or a quotient/remainder pair.
- ITER: one partial step per cycle. Counter increments each edge. The edge on which the counter equals DATA_WIDTH-1 moves the state to DONE.
- DONE: lasts exactly one cycle. res_valid=1.
  - res holds the low product for MUL, the high product for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, and the remainder for REM/REMU, with sign correction applied.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
  - rd_out equals the latched rd. The next state is always IDLE.
  - req_ready=0 in DONE; a request presented then is taken in the following IDLE cycle.
- res and rd_out hold their last value outside DONE; only res_valid qualifies them.
- stall is combinational and covers the gap until DONE: stall = (IDLE & req_valid & !fast_path & !flush) | ITER.
  - stall is 0 in DONE, so EX retires the result in the same cycle.
- Latency: iterative ops take DATA_WIDTH+1 cycles from the acceptance edge to the res_valid cycle. Fast-path ops take 1 cycle.
- flush has priority over everything except reset. In ITER or DONE it forces IDLE on the next edge, with res_valid 0 in the following cycle. In IDLE it blocks acceptance.
- Simultaneous flush and req_valid in IDLE: no acceptance, stall=0.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3): res=0xFFFFFFEB. res_valid exactly 33 cycles after the acceptance edge. stall high for 32 cycles, low in the DONE cycle. rd_out=5 when rd_in=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF: res=0xFFFFFFFE. MULH 0x80000000 x 0x80000000: res=0x40000000. MULHSU 0xFFFFFFFF x 2: res=0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2: res=0xFFFFFFFD. REM of the same operands: res=0xFFFFFFFF. DIVU 100/7: res=14. REMU 100/7: res=2.
- DIVU 5/0: res=0xFFFFFFFF and REM 5/0: res=5, each with res_valid one cycle after acceptance and stall never high. DIV 0x80000000/0xFFFFFFFF: res=0x80000000. REM of the same operands: res=0.
- Pulse flush at ITER cycle 10: returns to IDLE, no res_valid. A back-to-back request two cycles later completes with the correct result.
- Deassert rst_n at ITER cycle 20: next cycle state IDLE, res_valid=0, res=0, rd_out=0, stall=0, req_ready=1.
